// File: rtl/alu_mem_io_unit.sv
// Data-side execution block: 32-bit ALU, load/store address decode splitting
// accesses between internal word memory and the external IO port.
module alu_mem_io_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [3:0]  alu_control,
  output logic [31:0] alu_result,
  output logic        zero,
  input  logic        data_read_en,
  input  logic        data_write_en,
  input  logic [31:0] data_write_value,
  output logic [31:0] data_read_value,
  output logic        is_io,
  output logic [31:0] io_address,
  output logic        io_read_en,
  output logic        io_write_en,
  output logic [31:0] io_write_value,
  input  logic [31:0] io_read_value
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001
  } alu_op_e;

  logic [31:0]      mem_q [MEM_WORDS];
  logic [IDX_W-1:0] mem_idx;
  logic             mem_read_en;
  logic             mem_write_en;
  logic [31:0]      mem_rdata;
  logic [4:0]       shamt;

  assign shamt = alu_b[4:0];

  always_comb begin
    alu_result = 32'h0;
    case (alu_op_e'(alu_control))
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_SLL:  alu_result = alu_a << shamt;
      OP_SRL:  alu_result = alu_a >> shamt;
      OP_SRA:  alu_result = $unsigned($signed(alu_a) >>> shamt);
      OP_SLT:  alu_result = {31'h0, $signed(alu_a) < $signed(alu_b)};
      OP_SLTU: alu_result = {31'h0, alu_a < alu_b};
      default: alu_result = 32'h0;
    endcase
  end

  assign zero = (alu_result == 32'h0);

  // Bit 31 selects IO; everything else below it aliases into the word memory.
  assign is_io          = alu_result[31];
  assign io_address     = alu_result;
  assign io_write_value = data_write_value;
  assign io_read_en     = data_read_en & is_io;
  assign io_write_en    = data_write_en & is_io;
  assign mem_read_en    = data_read_en & ~is_io;
  assign mem_write_en   = data_write_en & ~is_io;
  assign mem_idx        = alu_result[IDX_W+1:2];

  assign mem_rdata       = mem_read_en ? mem_q[mem_idx] : 32'h0;
  assign data_read_value = is_io ? io_read_value : mem_rdata;

  // Reset clears every word and wins over a concurrent store.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= 32'h0;
    end else if (mem_write_en) begin
      mem_q[mem_idx] <= data_write_value;
    end
  end

endmodule

// File: tb/tb_alu_mem_io_unit.sv
// Directed self-checking bench for alu_mem_io_unit: ALU ops, memory, aliasing,
// IO routing, read-during-write and reset priority.
module tb_alu_mem_io_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        zero;
  logic        data_read_en, data_write_en;
  logic [31:0] data_write_value, data_read_value;
  logic        is_io;
  logic [31:0] io_address;
  logic        io_read_en, io_write_en;
  logic [31:0] io_write_value, io_read_value;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_mem_io_unit #(.MEM_WORDS(64)) dut (
    .clk(clk), .reset(reset),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .zero(zero),
    .data_read_en(data_read_en), .data_write_en(data_write_en),
    .data_write_value(data_write_value), .data_read_value(data_read_value),
    .is_io(is_io), .io_address(io_address),
    .io_read_en(io_read_en), .io_write_en(io_write_en),
    .io_write_value(io_write_value), .io_read_value(io_read_value)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge and settle before checking.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input logic re, input logic we, input logic [31:0] wv);
    @(negedge clk);
    alu_a = a; alu_b = b; alu_control = op;
    data_read_en = re; data_write_en = we; data_write_value = wv;
    #1;
  endtask

  task automatic load(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    drive(addr, 32'h0, 4'b0000, 1'b1, 1'b0, 32'h0);
    chk(tag, data_read_value, exp);
  endtask

  initial begin
    reset = 1'b1;
    alu_a = '0; alu_b = '0; alu_control = '0;
    data_read_en = 1'b0; data_write_en = 1'b0; data_write_value = '0;
    io_read_value = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_alu_result", alu_result, 32'h0);
    chk("rst_zero", {31'h0, zero}, 32'h1);
    chk("rst_read_value", data_read_value, 32'h0);
    chk("rst_is_io", {31'h0, is_io}, 32'h0);
    chk("rst_io_read_en", {31'h0, io_read_en}, 32'h0);
    chk("rst_io_write_en", {31'h0, io_write_en}, 32'h0);
    chk("rst_io_address", io_address, 32'h0);
    chk("rst_io_write_value", io_write_value, 32'h0);

    drive(32'd7, 32'd5, 4'b0000, 0, 0, 0);
    chk("add", alu_result, 32'd12);
    chk("add_zero", {31'h0, zero}, 32'h0);
    drive(32'd5, 32'd5, 4'b0001, 0, 0, 0);
    chk("sub", alu_result, 32'd0);
    chk("sub_zero", {31'h0, zero}, 32'h1);
    drive(32'h0000_F0F0, 32'h0000_FF00, 4'b0010, 0, 0, 0);
    chk("and", alu_result, 32'h0000_F000);
    drive(32'h0000_F0F0, 32'h0000_FF00, 4'b0011, 0, 0, 0);
    chk("or", alu_result, 32'h0000_FFF0);
    drive(32'h0000_F0F0, 32'h0000_FF00, 4'b0100, 0, 0, 0);
    chk("xor", alu_result, 32'h0000_0FF0);
    drive(32'h1, 32'd33, 4'b0101, 0, 0, 0);
    chk("sll_shamt5", alu_result, 32'h2);
    drive(32'h8000_0000, 32'd31, 4'b0110, 0, 0, 0);
    chk("srl", alu_result, 32'h1);
    drive(32'h8000_0000, 32'd4, 4'b0111, 0, 0, 0);
    chk("sra", alu_result, 32'hF800_0000);
    drive(32'hFFFF_FFFF, 32'd1, 4'b1000, 0, 0, 0);
    chk("slt", alu_result, 32'h1);
    drive(32'hFFFF_FFFF, 32'd1, 4'b1001, 0, 0, 0);
    chk("sltu", alu_result, 32'h0);
    drive(32'd7, 32'd5, 4'b1111, 0, 0, 0);
    chk("op_1111", alu_result, 32'h0);

    // Store/load word 5
    drive(32'h10, 32'h4, 4'b0000, 0, 1, 32'hDEAD_BEEF);
    chk("st_addr", alu_result, 32'h14);
    chk("st_io_write_en", {31'h0, io_write_en}, 32'h0);
    load("ld_deadbeef", 32'h14, 32'hDEAD_BEEF);
    drive(32'h14, 32'h0, 4'b0000, 0, 0, 0);
    chk("ld_disabled", data_read_value, 32'h0);

    // Aliasing/alignment: 0x8, 0x108, 0xB all map to word 2
    drive(32'h8, 32'h0, 4'b0000, 0, 1, 32'h1234);
    load("alias_108", 32'h108, 32'h1234);
    load("align_b", 32'hB, 32'h1234);

    // IO store must not touch word 1
    drive(32'h4, 32'h0, 4'b0000, 0, 1, 32'h77);
    drive(32'h8000_0004, 32'h0, 4'b0000, 0, 1, 32'hA5);
    chk("io_is_io", {31'h0, is_io}, 32'h1);
    chk("io_write_en", {31'h0, io_write_en}, 32'h1);
    chk("io_write_value", io_write_value, 32'hA5);
    chk("io_address", io_address, 32'h8000_0004);
    load("io_mem_unchanged", 32'h4, 32'h77);
    io_read_value = 32'h55;
    drive(32'h8000_0004, 32'h0, 4'b0000, 1, 0, 0);
    chk("io_load", data_read_value, 32'h55);
    chk("io_read_en", {31'h0, io_read_en}, 32'h1);
    drive(32'h8000_0004, 32'h0, 4'b0000, 0, 0, 0);
    chk("io_passthru", data_read_value, 32'h55);
    chk("io_read_en_low", {31'h0, io_read_en}, 32'h0);
    io_read_value = 32'h0;

    // Read-during-write on word 3
    drive(32'hC, 32'h0, 4'b0000, 0, 1, 32'h11);
    drive(32'hC, 32'h0, 4'b0000, 1, 1, 32'h22);
    chk("rdw_old", data_read_value, 32'h11);
    load("rdw_new", 32'hC, 32'h22);

    // Reset with concurrent store to word 4
    @(negedge clk);
    reset = 1'b1;
    alu_a = 32'h10; alu_b = 32'h0; alu_control = 4'b0000;
    data_read_en = 1'b0; data_write_en = 1'b1; data_write_value = 32'h99;
    @(negedge clk);
    reset = 1'b0;
    data_write_en = 1'b0;
    load("rst_w1", 32'h4, 32'h0);
    load("rst_w2", 32'h8, 32'h0);
    load("rst_w3", 32'hC, 32'h0);
    load("rst_w4_discard", 32'h10, 32'h0);
    load("rst_w5", 32'h14, 32'h0);
    drive(32'h0, 32'h0, 4'b0000, 0, 1, 32'h5A);
    load("post_rst_store", 32'h0, 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
